fetch_prefetch_unit: RTL

- Parametrised instruction fetch front-end. Owns the PC and issues word-aligned requests to instruction memory with a req/gnt handshake.
- Tracks in-order responses and buffers fetched instructions with their PCs in a prefetch FIFO.
- Presents instructions to decode through a valid/ready interface.
- Supports redirect (branch/jump/trap) with FIFO flush and discard of stale in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_prefetch_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
//   XLEN_DEF      : default address/instruction width
//   RESET_PC_DEF  : default first fetch address after reset
//   INSTR_BYTES   : bytes per fetched instruction word
//   fetch_entry_t : {instr, pc} pair stored in the fetch FIFOs
package fetch_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned INSTR_BYTES  = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wdata  : enqueue (ignored when full unless a pop frees a slot)
//   pop          : dequeue head (ignored when empty)
//   flush        : drop all entries; wins over push/pop
//   rdata        : head entry (meaningful only while !empty)
//   full, empty, count : occupancy status
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, wptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; readers qualify with empty.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: owns the PC, issues word-aligned req/gnt fetches,
// tracks in-order responses and buffers {instr, pc} for decode.
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   imem_req_o/addr_o      : fetch request and word-aligned address
//   imem_gnt_i             : request accepted this cycle
//   imem_rvalid_i/rdata_i  : in-order response
//   redirect_i/redirect_pc_i : flush and restart fetch at a new PC
//   instr_valid_o/ready_i  : decode handshake; instr_o/instr_pc_o is the head entry
// Optional (`define FETCH_PERF_CNT_EN):
//   perf_fetched_o   : saturating count of entries popped by decode
//   perf_discarded_o : saturating count of dropped responses plus flushed entries
// fetch_entry_t is sized by fetch_pkg, so XLEN must equal fetch_pkg::XLEN_DEF.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEF,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned     CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_discarded_o
`endif
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic             fetch_en_q;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] occupancy, outstanding;
    logic [SUM_W-1:0] credit_used;
    fetch_entry_t     fifo_wdata, fifo_head, infl_wdata, infl_head;
    logic             fifo_full, fifo_empty, infl_full, infl_empty;
    logic             grant, rsp, drop, fifo_push, fifo_pop;

    // Every granted request reserves a FIFO slot, so the FIFO never overflows.
    assign credit_used = SUM_W'(occupancy) + SUM_W'(outstanding);
    assign imem_req_o  = fetch_en_q && !redirect_i && (credit_used < SUM_W'(FIFO_DEPTH));
    assign imem_addr_o = fetch_pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding is ignored.
    assign rsp       = imem_rvalid_i && !infl_empty;
    assign drop      = rsp && (redirect_i || (discard_q != '0));
    assign fifo_push = rsp && !drop;
    // A pop during redirect is not honoured; the head is flushed instead.
    assign fifo_pop  = instr_valid_o && instr_ready_i && !redirect_i;

    assign infl_wdata.instr = '0;
    assign infl_wdata.pc    = fetch_pc_q;
    assign fifo_wdata.instr = imem_rdata_i;
    assign fifo_wdata.pc    = infl_head.pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            // Everything still in flight is stale; a same-cycle response is already dropped.
            discard_d  = outstanding - CNT_W'(rsp);
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            if (rsp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_en_q <= 1'b0;
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_en_q <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_prefetch_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (redirect_i),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // PCs of granted requests; its occupancy is the outstanding count.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inflight_fifo (
        .clock (clock),
        .reset (reset),
        .push  (grant),
        .wdata (infl_wdata),
        .pop   (rsp),
        .flush (1'b0),
        .rdata (infl_head),
        .full  (infl_full),
        .empty (infl_empty),
        .count (outstanding)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = instr_valid_o ? fifo_head.instr : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_head.pc : '0;

    logic unused_sigs;
    assign unused_sigs = ^{fifo_full, infl_full, infl_head.instr, redirect_pc_i[1:0]};

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_discarded_q, disc_inc;
    logic [32:0] disc_sum;

    assign disc_inc = 32'(drop) + (redirect_i ? 32'(occupancy) : 32'd0);
    assign disc_sum = {1'b0, perf_discarded_q} + {1'b0, disc_inc};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else begin
            if (fifo_pop && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
            perf_discarded_q <= disc_sum[32] ? '1 : disc_sum[31:0];
        end
    end

    assign perf_fetched_o   = perf_fetched_q;
    assign perf_discarded_o = perf_discarded_q;
`endif

    rsp_needs_outstanding: assert property (
        @(posedge clock) disable iff (reset) imem_rvalid_i |-> !infl_empty
    );

endmodule
